param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 19 +
 rtl/param_fifo_if.sv | 26 ++
 rtl/fifo_ptr.sv | 32 +++
 rtl/param_fifo.sv | 121 ++++++++++++
 tb/tb_param_fifo.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and width helpers for the parametrised FIFO
// Provides default word width / depth and the pointer and occupancy width
// functions used by param_fifo, fifo_ptr and param_fifo_if.
package fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    // Pointer width: enough bits to address DEPTH entries.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so that count can reach DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - push/pop data handshake bundle of param_fifo
// Signals:
//   push, pop, data_in : requester -> FIFO
//   data_out, rd_valid : FIFO -> requester (registered in the FIFO)
// Modports: master = requester side, slave = FIFO side.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;

    modport master (
        output push, pop, data_in,
        input  data_out, rd_valid
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, rd_valid
    );
endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-around pointer with enable and synchronous clear
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   en       : advance pointer by one (DEPTH-1 wraps to 0)
//   clr      : synchronous clear to 0, wins over en
//   ptr      : current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised circular-buffer FIFO with threshold and sticky error flags
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   bus (slave)         : push/pop/data_in in, data_out/rd_valid out (registered)
//   flush               : synchronous clear of pointers and count, overrides push/pop
//   clr_err             : synchronous clear of overflow/underflow
//   fifo_ful, fifo_emp  : count==DEPTH / count==0
//   almost_full         : count >= AF_LEVEL
//   almost_empty        : count <= AE_LEVEL
//   count               : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int PW      = ptr_width(DEPTH),
    localparam int CW      = count_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    param_fifo_if.slave         bus,
    input  logic                flush,
    input  logic                clr_err,
    output logic                fifo_ful,
    output logic                fifo_emp,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [CW-1:0]       count,
    output logic                overflow,
    output logic                underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] data_out_q;
    logic             rd_valid_q;

    logic pop_ok;
    logic push_ok;
    logic push_acc;
    logic pop_acc;
    logic ovf_set;
    logic unf_set;

    // Flags are decoded from the registered count only, so no combinational
    // path exists from push/pop to any output.
    assign fifo_ful     = (count == CW'(DEPTH));
    assign fifo_emp     = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A push into a full FIFO is still accepted when a pop frees a slot in
    // the same cycle; the read sees the old word (read-before-write).
    assign pop_ok   = bus.pop & ~fifo_emp;
    assign push_ok  = bus.push & (~fifo_ful | pop_ok);
    assign push_acc = push_ok & ~flush;
    assign pop_acc  = pop_ok & ~flush;

    // Flush leaves the error flags untouched, so rejections during a flush
    // cycle are not reported.
    assign ovf_set = bus.push & ~push_ok & ~flush;
    assign unf_set = bus.pop & fifo_emp & ~flush;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_acc),
        .clr (flush),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_acc),
        .clr (flush),
        .ptr (rd_ptr)
    );

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            rd_valid_q <= pop_acc;
            if (pop_acc) begin
                data_out_q <= mem[rd_ptr];
            end

            if (flush) begin
                count <= '0;
            end else if (push_acc && !pop_acc) begin
                count <= count + 1'b1;
            end else if (pop_acc && !push_acc) begin
                count <= count - 1'b1;
            end

            // A new error in the clr_err cycle wins over the clear.
            overflow  <= ovf_set | (overflow & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo against a queue-based model
module tb_param_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       clr_err;
    logic       fifo_ful;
    logic       fifo_emp;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_do;
    logic             m_rv;
    logic             m_ovf;
    logic             m_unf;

    always #5 clk = ~clk;

    param_fifo_if #(.WIDTH(WIDTH)) bus ();

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush        (flush),
        .clr_err      (clr_err),
        .fifo_ful     (fifo_ful),
        .fifo_emp     (fifo_emp),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(m_do));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rv));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"}, 32'(fifo_ful), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(fifo_emp), 32'(q.size() == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= DEPTH - 1));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= 1));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_do  = '0;
        m_rv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input bit p, input bit o, input bit f, input bit c,
                        input logic [WIDTH-1:0] d, input string tag);
        bit full_now, empty_now, pop_acc, push_acc;
        bus.push    = p;
        bus.pop     = o;
        bus.data_in = d;
        flush       = f;
        clr_err     = c;
        @(posedge clk);
        full_now  = (q.size() == DEPTH);
        empty_now = (q.size() == 0);
        if (f) begin
            q.delete();
            m_rv  = 1'b0;
            m_ovf = m_ovf & ~c;
            m_unf = m_unf & ~c;
        end else begin
            pop_acc  = o && !empty_now;
            push_acc = p && (!full_now || pop_acc);
            m_rv = pop_acc;
            if (pop_acc) m_do = q.pop_front();
            if (push_acc) q.push_back(d);
            m_ovf = (p && !push_acc) | (m_ovf & ~c);
            m_unf = (o && empty_now) | (m_unf & ~c);
        end
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        flush    = 1'b0;
        clr_err  = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        rst         = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        flush       = 1'b0;
        clr_err     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_all("reset");
        chk("reset.empty_const", 32'(fifo_emp), 32'd1);

        // In-order fill and drain.
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, 16'hA000 + 16'(i), "fill");
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, '0, "drain");
            chk("drain.word", 32'(bus.data_out), 32'(16'hA000 + 16'(i)));
        end
        step(0, 0, 0, 0, '0, "drain.idle");

        // Overflow on full, pushed word never appears.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h1100 + 16'(i), "ovf.fill");
        step(1, 0, 0, 0, 16'hBEEF, "ovf.push");
        chk("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, '0, "ovf.drain");
            chk("ovf.word", 32'(bus.data_out), 32'(16'h1100 + 16'(i)));
        end
        step(0, 0, 0, 1, '0, "ovf.clr");

        // Simultaneous push/pop on full.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h2200 + 16'(i), "fpp.fill");
        step(1, 1, 0, 0, 16'hC005, "fpp.both");
        chk("fpp.oldest", 32'(bus.data_out), 32'h2200);
        chk("fpp.count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0, "fpp.drain");
        chk("fpp.last", 32'(bus.data_out), 32'hC005);

        // Underflow on empty; clear; push+pop on empty.
        step(0, 1, 0, 0, '0, "unf.pop");
        chk("unf.flag", 32'(underflow), 32'd1);
        step(0, 0, 0, 1, '0, "unf.clr");
        step(1, 1, 0, 0, 16'h3333, "epp.both");
        chk("epp.count", 32'(count), 32'd1);
        step(0, 1, 1, 1, '0, "clr_vs_set");

        // Interleaved traffic with pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1, (i % 3) != 0, 0, 0, 16'h4400 + 16'(i), "wrap");
        end
        while (q.size() != 0) step(0, 1, 0, 0, '0, "wrap.drain");

        // Asynchronous reset at count 3.
        for (int i = 0; i < 3; i++) step(1, i == 2, 0, 0, 16'h5500 + 16'(i), "ar.fill");
        step(1, 0, 0, 0, 16'h5599, "ar.fill2");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 1, 0, 0, '0, "ar.pop_rejected");

        // Flush at count 2 holds data_out.
        step(1, 0, 0, 0, 16'h6600, "fl.fill");
        step(0, 1, 0, 0, '0, "fl.pop");
        step(1, 0, 0, 0, 16'h6601, "fl.fill");
        step(1, 0, 0, 0, 16'h6602, "fl.fill");
        step(1, 1, 1, 0, 16'h6603, "flush");
        chk("flush.held", 32'(bus.data_out), 32'h6600);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 16'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
